// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that borrows
// the shared EX-stage ALU (driven as an adder) for its per-iteration add.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   start, op_a, op_b         - request and operands; start sampled only when not busy
//   busy, done                - busy while iterating; done pulses one cycle with product valid
//   product_hi, product_lo    - 64-bit product, held until the next accepted start
//   alu_a, alu_b, alu_control - drive the shared ALU (control fixed to add)
//   alu_result, alu_zero      - ALU response; alu_zero is not used
module alu_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0]       ALU_ADD   = 3'b010;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             carry;

  // The zero flag carries no information for multiplication.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // ALU drive: add the multiplicand into the high half when the current multiplier bit is set.
  always_comb begin
    alu_control = ALU_ADD;
    alu_a       = acc_hi_q;
    alu_b       = '0;
    if (state_q == S_RUN && acc_lo_q[0]) begin
      alu_b = mcand_q;
    end
  end

  // The ALU has no carry out; an unsigned add wrapped iff the sum is below an operand.
  assign carry = (alu_result < acc_hi_q);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          mcand_d  = op_a;
          acc_hi_d = '0;
          acc_lo_d = op_b;
          count_d  = '0;
          state_d  = S_RUN;
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        // Shift the 2*WIDTH+1-bit sum right by one; the multiplier drains out of acc_lo.
        {acc_hi_d, acc_lo_d} = {carry, alu_result, acc_lo_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        busy_d  = 1'b1;
        if (count_q == LAST_ITER) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign product_hi = acc_hi_q;
  assign product_lo = acc_lo_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq: the bench plays the shared ALU (adder on
// control 3'b010), queues hand-computed products at each start, and a monitor
// compares them whenever done is seen.
module tb_alu_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product_hi, product_lo;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  // ALU model: only the add encoding produces a sum.
  assign alu_result = (alu_control == 3'b010) ? (alu_a + alu_b) : 32'h0;
  assign alu_zero   = (alu_result == 32'h0);

  alu_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue the expected product and raise start for the next edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prod);
    exp_q.push_back(prod);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
  endtask

  // Let the pending start be taken, then count busy cycles until done (bounded).
  // With inject set, start is pulsed with other operands on busy cycles 5 and 20.
  task automatic wait_done(input bit inject);
    int  n = 0;
    bit  seen = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      start = inject && (n == 5 || n == 20);
      if (start) begin
        op_a = 32'hAAAA5555;
        op_b = 32'h00FF00FF;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(n), 64'd32);
  endtask

  // After a lone done pulse the block must be idle again.
  task automatic check_idle_after;
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int dcount;
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;

    fork
      // Monitor: each done must match the oldest queued product.
      forever begin
        @(negedge clk);
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got hi=%h lo=%h with no pending expectation",
                     product_hi, product_lo);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("product_hi", 64'(product_hi), 64'(e[63:32]));
            chk("product_lo", 64'(product_lo), 64'(e[31:0]));
          end
        end
      end
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(product_hi), 64'd0);
    chk("rst_lo", 64'(product_lo), 64'd0);
    chk("rst_alu_ctl", 64'(alu_control), 64'd2);
    chk("rst_alu_b", 64'(alu_b), 64'd0);

    // Small operands.
    @(posedge clk); #1;
    issue(32'd3, 32'd5, 64'd15);
    wait_done(0);
    check_idle_after();

    // All ones: carry out of the high half on most iterations.
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    wait_done(0);
    check_idle_after();

    // Zero operands on either side.
    issue(32'h12345678, 32'h0, 64'h0);
    wait_done(0);
    check_idle_after();
    issue(32'h0, 32'hDEADBEEF, 64'h0);
    wait_done(0);
    check_idle_after();

    // Starts while busy are ignored: only 100*200 is produced, once.
    issue(32'd100, 32'd200, 64'd20000);
    wait_done(1);
    check_idle_after();

    // Reset in the middle of a run aborts it without a done pulse.
    op_a  = 32'hFFFFFFFF;
    op_b  = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(product_hi), 64'd0);
    chk("abort_lo", 64'(product_lo), 64'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);

    // Back-to-back: start held in the DONE cycle launches the next multiply.
    @(posedge clk); #1;
    issue(32'h00010000, 32'h00010000, 64'h00000001_00000000);
    wait_done(0);
    issue(32'd7, 32'd9, 64'd63);
    wait_done(0);
    check_idle_after();

    // Outputs hold the last product while idle.
    repeat (3) @(negedge clk);
    chk("hold_hi", 64'(product_hi), 64'd0);
    chk("hold_lo", 64'(product_lo), 64'd63);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
